seg_reader: RTL and testbench

SEG_READER -- requirements
Module: seg_reader

---
 rtl/seg_pkg.sv | 43 ++++
 rtl/seg_glyph_dec.sv | 16 +
 rtl/seg_reader.sv | 128 ++++++++++++
 tb/tb_seg_reader.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - shared types, glyph constants and decode helpers for seg_reader
// Segment bit order throughout: seg[6]=a, seg[5]=b, ... seg[0]=g.
package seg_pkg;

    typedef enum logic [1:0] {
        ST_WAIT  = 2'd0,
        ST_COUNT = 2'd1,
        ST_HELD  = 2'd2
    } samp_state_t;

    localparam logic [6:0] GLYPH_0 = 7'b1111110;  // abcdef
    localparam logic [6:0] GLYPH_1 = 7'b0110000;  // bc
    localparam logic [6:0] GLYPH_2 = 7'b1101101;  // abdeg
    localparam logic [6:0] GLYPH_3 = 7'b1111001;  // abcdg
    localparam logic [6:0] GLYPH_4 = 7'b0110011;  // bcfg
    localparam logic [6:0] GLYPH_5 = 7'b1011011;  // acdfg
    localparam logic [6:0] GLYPH_6 = 7'b1011111;  // acdefg
    localparam logic [6:0] GLYPH_7 = 7'b1110000;  // abc
    localparam logic [6:0] GLYPH_8 = 7'b1111111;  // abcdefg
    localparam logic [6:0] GLYPH_9 = 7'b1111011;  // abcdfg

    // Returns {illegal, value}; anything that is not a decimal glyph maps to F.
    function automatic logic [4:0] glyph_decode(input logic [6:0] pattern);
        case (pattern)
            GLYPH_0: return {1'b0, 4'd0};
            GLYPH_1: return {1'b0, 4'd1};
            GLYPH_2: return {1'b0, 4'd2};
            GLYPH_3: return {1'b0, 4'd3};
            GLYPH_4: return {1'b0, 4'd4};
            GLYPH_5: return {1'b0, 4'd5};
            GLYPH_6: return {1'b0, 4'd6};
            GLYPH_7: return {1'b0, 4'd7};
            GLYPH_8: return {1'b0, 4'd8};
            GLYPH_9: return {1'b0, 4'd9};
            default: return {1'b1, 4'hF};
        endcase
    endfunction

    function automatic logic is_onehot4(input logic [3:0] v);
        return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
    endfunction

endpackage

// File: rtl/seg_glyph_dec.sv
// rtl/seg_glyph_dec.sv - combinational 7-segment pattern to BCD decoder
// Ports:
//   pattern - 7-bit segment pattern (a..g, MSB first)
//   value   - decoded decimal digit, F for an illegal pattern
//   illegal - 1 when pattern is not one of the ten decimal glyphs
module seg_glyph_dec
    import seg_pkg::*;
(
    input  logic [6:0] pattern,
    output logic [3:0] value,
    output logic       illegal
);

    assign {illegal, value} = glyph_decode(pattern);

endmodule

// File: rtl/seg_reader.sv
// rtl/seg_reader.sv - multiplexed 4-digit 7-segment display reader with frame output
// Ports:
//   clk, nrst          - clock, asynchronous active-low reset
//   seg[6:0]           - segment lines (a..g), active-high
//   dig_sel[3:0]       - one-hot digit strobe, dig_sel[k] selects digit k
//   out_ready          - consumer accepts the current frame
//   out_valid          - frame available, held until accepted
//   out_bcd[15:0]      - digit k in bits [4k+3:4k]
//   out_err[3:0]       - per-digit illegal-glyph flags
//   overrun            - sticky, a completed frame was dropped
module seg_reader
    import seg_pkg::*;
#(
    parameter int STABLE_CYC = 4
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic [6:0]  seg,
    input  logic [3:0]  dig_sel,
    input  logic        out_ready,
    output logic        out_valid,
    output logic [15:0] out_bcd,
    output logic [3:0]  out_err,
    output logic        overrun
);

    // Capture happens on the sample that brings the count up to STABLE_CYC.
    localparam logic [3:0] LAST_CNT = 4'(STABLE_CYC - 1);

    samp_state_t state;
    logic [3:0]  count;
    logic [3:0]  ref_sel;
    logic [6:0]  ref_seg;
    logic [3:0]  mask;
    logic [15:0] slot_bcd;
    logic [3:0]  slot_err;

    logic [3:0]  dec_value;
    logic        dec_illegal;
    logic        same;
    logic        frame_full;

    seg_glyph_dec u_dec (
        .pattern (ref_seg),
        .value   (dec_value),
        .illegal (dec_illegal)
    );

    assign same       = ({dig_sel, seg} == {ref_sel, ref_seg});
    assign frame_full = (mask == 4'hF);

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state    <= ST_WAIT;
            count    <= 4'd0;
            ref_sel  <= 4'd0;
            ref_seg  <= 7'd0;
            mask     <= 4'd0;
            slot_bcd <= 16'd0;
            slot_err <= 4'd0;
        end else begin
            // A full mask is consumed by the output stage on this edge.
            if (frame_full) begin
                mask <= 4'd0;
            end
            case (state)
                ST_WAIT: begin
                    if (is_onehot4(dig_sel)) begin
                        ref_sel <= dig_sel;
                        ref_seg <= seg;
                        count   <= 4'd1;
                        state   <= ST_COUNT;
                    end
                end
                ST_COUNT: begin
                    // ref_sel is one-hot, so a multi-hot/zero strobe is a mismatch.
                    if (same) begin
                        count <= count + 4'd1;
                        if (count == LAST_CNT) begin
                            for (int k = 0; k < 4; k++) begin
                                if (ref_sel[k]) begin
                                    slot_bcd[4*k +: 4] <= dec_value;
                                    slot_err[k]        <= dec_illegal;
                                    mask[k]            <= 1'b1;
                                end
                            end
                            state <= ST_HELD;
                        end
                    end else begin
                        count <= 4'd0;
                        state <= ST_WAIT;
                    end
                end
                ST_HELD: begin
                    // Stay put until the strobe moves so one period gives one capture.
                    if (!same) begin
                        count <= 4'd0;
                        state <= ST_WAIT;
                    end
                end
                default: begin
                    count <= 4'd0;
                    state <= ST_WAIT;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            out_valid <= 1'b0;
            out_bcd   <= 16'd0;
            out_err   <= 4'd0;
            overrun   <= 1'b0;
        end else if (frame_full) begin
            if (!out_valid || out_ready) begin
                out_valid <= 1'b1;
                out_bcd   <= slot_bcd;
                out_err   <= slot_err;
            end else begin
                overrun <= 1'b1;
            end
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_seg_reader.sv
// tb/tb_seg_reader.sv - self-checking bench for seg_reader
module tb_seg_reader;

    logic        clk = 1'b0;
    logic        nrst;
    logic [6:0]  seg;
    logic [3:0]  dig_sel;
    logic        out_ready;
    logic        out_valid;
    logic [15:0] out_bcd;
    logic [3:0]  out_err;
    logic        overrun;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    seg_reader #(.STABLE_CYC(4)) dut (
        .clk       (clk),
        .nrst      (nrst),
        .seg       (seg),
        .dig_sel   (dig_sel),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_bcd   (out_bcd),
        .out_err   (out_err),
        .overrun   (overrun)
    );

    typedef struct {
        logic [6:0]  p0;
        logic [6:0]  p1;
        logic [6:0]  p2;
        logic [6:0]  p3;
        logic [15:0] bcd;
        logic [3:0]  err;
    } frame_t;

    frame_t rows[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Apply inputs at a falling edge, take one rising edge, return at the next falling edge.
    task automatic cyc(input logic [3:0] s, input logic [6:0] p, input logic r);
        dig_sel   = s;
        seg       = p;
        out_ready = r;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic digit(input int k, input logic [6:0] p, input logic r);
        repeat (4) cyc(4'(1 << k), p, r);
    endtask

    // Digits 0..3, 4 samples each, a blank between them; returns on the last capture edge.
    task automatic send_frame(input logic [6:0] p0, input logic [6:0] p1,
                              input logic [6:0] p2, input logic [6:0] p3, input logic r);
        digit(0, p0, r); cyc(4'h0, 7'h00, r);
        digit(1, p1, r); cyc(4'h0, 7'h00, r);
        digit(2, p2, r); cyc(4'h0, 7'h00, r);
        digit(3, p3, r);
    endtask

    task automatic do_reset();
        nrst = 1'b0;
        repeat (2) cyc(4'h0, 7'h00, 1'b0);
        nrst = 1'b1;
        cyc(4'h0, 7'h00, 1'b0);
    endtask

    initial begin
        rows[0] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 16'h3210, 4'b0000};
        rows[1] = '{7'h33, 7'h5B, 7'h5F, 7'h70, 16'h7654, 4'b0000};
        rows[2] = '{7'h7F, 7'h7B, 7'h7E, 7'h30, 16'h1098, 4'b0000};
        rows[3] = '{7'h7E, 7'h30, 7'h04, 7'h79, 16'h3F10, 4'b0100};
        rows[4] = '{7'h00, 7'h7F, 7'h7F, 7'h01, 16'hF88F, 4'b1001};
        rows[5] = '{7'h5B, 7'h7C, 7'h33, 7'h70, 16'h74F5, 4'b0010};

        nrst = 1'b0; dig_sel = 4'h0; seg = 7'h00; out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_valid",   32'(out_valid), 32'h0);
        chk("rst_bcd",     32'(out_bcd),   32'h0);
        chk("rst_err",     32'(out_err),   32'h0);
        chk("rst_overrun", 32'(overrun),   32'h0);
        nrst = 1'b1;
        cyc(4'h0, 7'h00, 1'b1);

        // Table: full frames with the consumer always ready.
        for (int i = 0; i < 6; i++) begin
            send_frame(rows[i].p0, rows[i].p1, rows[i].p2, rows[i].p3, 1'b1);
            chk($sformatf("row%0d_latency", i), 32'(out_valid), 32'h0);
            cyc(4'h0, 7'h00, 1'b1);
            chk($sformatf("row%0d_valid", i), 32'(out_valid), 32'h1);
            chk($sformatf("row%0d_bcd", i),   32'(out_bcd),   32'(rows[i].bcd));
            chk($sformatf("row%0d_err", i),   32'(out_err),   32'(rows[i].err));
            cyc(4'h0, 7'h00, 1'b1);
            chk($sformatf("row%0d_drop", i),  32'(out_valid), 32'h0);
        end

        // Strobe one sample short of stable: digit 0 must not be captured.
        repeat (3) cyc(4'b0001, 7'h7E, 1'b1);
        repeat (2) cyc(4'b0010, 7'h30, 1'b1);
        cyc(4'h0, 7'h00, 1'b1);
        digit(1, 7'h30, 1'b1); cyc(4'h0, 7'h00, 1'b1);
        digit(2, 7'h6D, 1'b1); cyc(4'h0, 7'h00, 1'b1);
        digit(3, 7'h79, 1'b1); cyc(4'h0, 7'h00, 1'b1);
        cyc(4'h0, 7'h00, 1'b1);
        chk("short_novalid", 32'(out_valid), 32'h0);
        // Multi-hot strobe must not capture either.
        repeat (6) cyc(4'b0011, 7'h7B, 1'b1);
        cyc(4'h0, 7'h00, 1'b1);
        chk("multihot_novalid", 32'(out_valid), 32'h0);
        digit(0, 7'h7B, 1'b1); cyc(4'h0, 7'h00, 1'b1);
        chk("short_valid", 32'(out_valid), 32'h1);
        chk("short_bcd",   32'(out_bcd),   32'h3219);

        // Consumer stalled across two frames: first is held, second dropped.
        do_reset();
        send_frame(7'h7E, 7'h30, 7'h6D, 7'h79, 1'b0);
        cyc(4'h0, 7'h00, 1'b0);
        chk("ovr_first_valid", 32'(out_valid), 32'h1);
        chk("ovr_first_bcd",   32'(out_bcd),   32'h3210);
        chk("ovr_first_flag",  32'(overrun),   32'h0);
        send_frame(7'h33, 7'h5B, 7'h04, 7'h70, 1'b0);
        cyc(4'h0, 7'h00, 1'b0);
        chk("ovr_held_valid", 32'(out_valid), 32'h1);
        chk("ovr_held_bcd",   32'(out_bcd),   32'h3210);
        chk("ovr_held_err",   32'(out_err),   32'h0);
        chk("ovr_flag",       32'(overrun),   32'h1);
        cyc(4'h0, 7'h00, 1'b1);
        chk("ovr_drop_valid", 32'(out_valid), 32'h0);
        chk("ovr_sticky",     32'(overrun),   32'h1);

        // Second frame loads on the same edge as the handshake.
        do_reset();
        send_frame(7'h7E, 7'h30, 7'h6D, 7'h79, 1'b0);
        cyc(4'h0, 7'h00, 1'b0);
        send_frame(7'h33, 7'h5B, 7'h5F, 7'h70, 1'b0);
        chk("hs_before_bcd", 32'(out_bcd), 32'h3210);
        cyc(4'h0, 7'h00, 1'b1);
        chk("hs_valid",   32'(out_valid), 32'h1);
        chk("hs_bcd",     32'(out_bcd),   32'h7654);
        chk("hs_overrun", 32'(overrun),   32'h0);
        cyc(4'h0, 7'h00, 1'b1);
        chk("hs_drop", 32'(out_valid), 32'h0);

        // Reset after three captures discards the partial frame.
        digit(0, 7'h7E, 1'b1); cyc(4'h0, 7'h00, 1'b1);
        digit(1, 7'h30, 1'b1); cyc(4'h0, 7'h00, 1'b1);
        digit(2, 7'h6D, 1'b1); cyc(4'h0, 7'h00, 1'b1);
        nrst = 1'b0;
        #1;
        chk("mid_rst_valid",   32'(out_valid), 32'h0);
        chk("mid_rst_bcd",     32'(out_bcd),   32'h0);
        chk("mid_rst_err",     32'(out_err),   32'h0);
        chk("mid_rst_overrun", 32'(overrun),   32'h0);
        @(negedge clk);
        cyc(4'h0, 7'h00, 1'b1);
        nrst = 1'b1;
        cyc(4'h0, 7'h00, 1'b1);
        digit(3, 7'h79, 1'b1); cyc(4'h0, 7'h00, 1'b1);
        repeat (3) cyc(4'h0, 7'h00, 1'b1);
        chk("mid_rst_novalid", 32'(out_valid), 32'h0);
        digit(0, 7'h5B, 1'b1); cyc(4'h0, 7'h00, 1'b1);
        digit(1, 7'h5F, 1'b1); cyc(4'h0, 7'h00, 1'b1);
        digit(2, 7'h70, 1'b1); cyc(4'h0, 7'h00, 1'b1);
        chk("mid_rst_frame_valid", 32'(out_valid), 32'h1);
        chk("mid_rst_frame_bcd",   32'(out_bcd),   32'h3765);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
